digit_bbox_detect: RTL and testbench

Front end of the digit-recognition pipeline, directly upstream of the feature-extraction stage.
- Binarizes the incoming grey pixel stream and produces `th_flag` with its edge strobes.
- Produces frame-sync edge strobes and the modulo frame counter that the recognizer gates on.
- Measures the bounding box of foreground pixels inside a fixed search window, so the recognizer's scan lines track the digit instead of using hard-coded limits.

---
 rtl/digit_bbox_detect.sv | 130 +++++++++++++
 tb/tb_digit_bbox_detect.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_bbox_detect.sv
// Pixel binarizer, frame-sync edge detector, frame counter and ROI bounding-box tracker.
// Optional build macro DIGIT_BBOX_RUNFILT_EN: only pixels continuing a horizontal run qualify.
module digit_bbox_detect #(
  parameter logic [7:0]  THRESHOLD = 8'd100,
  parameter logic [11:0] ROI_X0    = 12'd100,
  parameter logic [11:0] ROI_X1    = 12'd380,
  parameter logic [11:0] ROI_Y0    = 12'd40,
  parameter logic [11:0] ROI_Y1    = 12'd230,
  parameter logic [2:0]  FRAME_NUM = 3'd4
) (
  input  logic        TFT_VCLK,
  input  logic        rst_n,
  input  logic        TFT_VS,
  input  logic        TFT_DE,
  input  logic [7:0]  gray,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  output logic [11:0] hcount_o,
  output logic [11:0] vcount_o,
  output logic        th_flag,
  output logic        th_flag_rise,
  output logic        th_flag_fall,
  output logic        TFT_VS_rise,
  output logic        TFT_VS_fall,
  output logic [2:0]  frame_cnt,
  output logic [11:0] hcount_l,
  output logic [11:0] hcount_r,
  output logic [11:0] vcount_l,
  output logic [11:0] vcount_r,
  output logic        bbox_valid
);

  logic        th_flag_d;
  logic        vs_r0;
  logic        vs_r1;
  logic [11:0] min_x;
  logic [11:0] max_x;
  logic [11:0] min_y;
  logic [11:0] max_y;
  logic        found;
  logic        in_roi;
  logic        qualify;

  always_ff @(posedge TFT_VCLK or negedge rst_n) begin
    if (!rst_n) begin
      th_flag   <= 1'b0;
      th_flag_d <= 1'b0;
      hcount_o  <= 12'd0;
      vcount_o  <= 12'd0;
      vs_r0     <= 1'b0;
      vs_r1     <= 1'b0;
    end else begin
      th_flag   <= TFT_DE & (gray < THRESHOLD);
      th_flag_d <= th_flag;
      hcount_o  <= hcount;
      vcount_o  <= vcount;
      vs_r0     <= TFT_VS;
      vs_r1     <= vs_r0;
    end
  end

  assign th_flag_rise = th_flag & ~th_flag_d;
  assign th_flag_fall = ~th_flag & th_flag_d;
  assign TFT_VS_rise  = vs_r0 & ~vs_r1;
  assign TFT_VS_fall  = ~vs_r0 & vs_r1;

  assign in_roi = (hcount_o >= ROI_X0) && (hcount_o <= ROI_X1) &&
                  (vcount_o >= ROI_Y0) && (vcount_o <= ROI_Y1);

`ifdef DIGIT_BBOX_RUNFILT_EN
  logic [11:0] hcount_p;

  always_ff @(posedge TFT_VCLK or negedge rst_n) begin
    if (!rst_n) begin
      hcount_p <= 12'd0;
    end else begin
      hcount_p <= hcount_o;
    end
  end

  // Needs two dark pixels in a row on the same line; isolated specks never qualify.
  assign qualify = th_flag & th_flag_d & (hcount_o == hcount_p + 12'd1) & in_roi;
`else
  assign qualify = th_flag & in_roi;
`endif

  always_ff @(posedge TFT_VCLK or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 3'd0;
    end else if (TFT_VS_rise) begin
      frame_cnt <= (frame_cnt == FRAME_NUM - 3'd1) ? 3'd0 : frame_cnt + 3'd1;
    end
  end

  // Frame end takes priority: a pixel coinciding with the VS strobe is dropped.
  always_ff @(posedge TFT_VCLK or negedge rst_n) begin
    if (!rst_n) begin
      min_x      <= 12'hFFF;
      max_x      <= 12'd0;
      min_y      <= 12'hFFF;
      max_y      <= 12'd0;
      found      <= 1'b0;
      hcount_l   <= ROI_X0;
      hcount_r   <= ROI_X1;
      vcount_l   <= ROI_Y0;
      vcount_r   <= ROI_Y1;
      bbox_valid <= 1'b0;
    end else if (TFT_VS_rise) begin
      if (found) begin
        hcount_l <= min_x;
        hcount_r <= max_x;
        vcount_l <= min_y;
        vcount_r <= max_y;
      end
      bbox_valid <= found;
      min_x      <= 12'hFFF;
      max_x      <= 12'd0;
      min_y      <= 12'hFFF;
      max_y      <= 12'd0;
      found      <= 1'b0;
    end else if (qualify) begin
      if (hcount_o < min_x) min_x <= hcount_o;
      if (hcount_o > max_x) max_x <= hcount_o;
      if (vcount_o < min_y) min_y <= vcount_o;
      if (vcount_o > max_y) max_y <= vcount_o;
      found <= 1'b1;
    end
  end

endmodule

// File: tb/tb_digit_bbox_detect.sv
// Randomized and directed bench for digit_bbox_detect against a sample-history reference model.
module tb_digit_bbox_detect;
  localparam logic [7:0]  THRESHOLD = 8'd100;
  localparam logic [11:0] ROI_X0 = 12'd100;
  localparam logic [11:0] ROI_X1 = 12'd380;
  localparam logic [11:0] ROI_Y0 = 12'd40;
  localparam logic [11:0] ROI_Y1 = 12'd230;
  localparam int FRAME_NUM = 4;
`ifdef DIGIT_BBOX_RUNFILT_EN
  localparam int RECT_L = 201;
  localparam int RUN_L = 211, RUN_R = 212, RUN_T = 120, RUN_B = 120;
`else
  localparam int RECT_L = 200;
  localparam int RUN_L = 150, RUN_R = 212, RUN_T = 100, RUN_B = 120;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic TFT_VS = 1'b0, TFT_DE = 1'b0;
  logic [7:0] gray = 8'd255;
  logic [11:0] hcount = 12'd0, vcount = 12'd0;
  logic [11:0] hcount_o, vcount_o, hcount_l, hcount_r, vcount_l, vcount_r;
  logic th_flag, th_flag_rise, th_flag_fall, TFT_VS_rise, TFT_VS_fall, bbox_valid;
  logic [2:0] frame_cnt;

  digit_bbox_detect #(
    .THRESHOLD(THRESHOLD), .ROI_X0(ROI_X0), .ROI_X1(ROI_X1), .ROI_Y0(ROI_Y0),
    .ROI_Y1(ROI_Y1), .FRAME_NUM(3'(FRAME_NUM))
  ) dut (
    .TFT_VCLK(clk), .rst_n(rst_n), .TFT_VS(TFT_VS), .TFT_DE(TFT_DE), .gray(gray),
    .hcount(hcount), .vcount(vcount), .hcount_o(hcount_o), .vcount_o(vcount_o),
    .th_flag(th_flag), .th_flag_rise(th_flag_rise), .th_flag_fall(th_flag_fall),
    .TFT_VS_rise(TFT_VS_rise), .TFT_VS_fall(TFT_VS_fall), .frame_cnt(frame_cnt),
    .hcount_l(hcount_l), .hcount_r(hcount_r), .vcount_l(vcount_l), .vcount_r(vcount_r),
    .bbox_valid(bbox_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vs;
    logic        de;
    logic [7:0]  g;
    logic [11:0] h;
    logic [11:0] v;
  } samp_t;

  // Reference state: the last three input samples plus the qualifying pixels of the open frame.
  samp_t s0, s1, s2;
  int px_q[$];
  int py_q[$];
  int box_l, box_r, box_t, box_b, exp_cnt, n_frames;
  bit exp_valid;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit fg(input samp_t s);
    return s.de && (s.g < THRESHOLD);
  endfunction

  function automatic bit qual(input samp_t cur, input samp_t prev);
    bit ok;
    ok = fg(cur) && cur.h >= ROI_X0 && cur.h <= ROI_X1 && cur.v >= ROI_Y0 && cur.v <= ROI_Y1;
`ifdef DIGIT_BBOX_RUNFILT_EN
    ok = ok && fg(prev) && (cur.h == 12'(prev.h + 12'd1));
`else
    ok = ok && (prev.h == prev.h);
`endif
    return ok;
  endfunction

  task automatic frame_end();
    if (px_q.size() > 0) begin
      box_l = px_q.min()[0];
      box_r = px_q.max()[0];
      box_t = py_q.min()[0];
      box_b = py_q.max()[0];
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    px_q.delete();
    py_q.delete();
    exp_cnt = (exp_cnt + 1) % FRAME_NUM;
  endtask

  task automatic model_reset();
    s0 = '0; s1 = '0; s2 = '0;
    px_q.delete();
    py_q.delete();
    box_l = ROI_X0; box_r = ROI_X1; box_t = ROI_Y0; box_b = ROI_Y1;
    exp_valid = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic drive_cycle(input logic vs, input logic de, input logic [7:0] g,
                             input logic [11:0] h, input logic [11:0] v);
    TFT_VS = vs; TFT_DE = de; gray = g; hcount = h; vcount = v;
    @(posedge clk);
    s2 = s1;
    s1 = s0;
    s0 = '{vs, de, g, h, v};
    if (s1.vs && !s2.vs) frame_end();
    else if (qual(s1, s2)) begin
      px_q.push_back(int'(s1.h));
      py_q.push_back(int'(s1.v));
    end
    @(negedge clk);
    check("th_flag", th_flag, fg(s0));
    check("hcount_o", hcount_o, s0.h);
    check("vcount_o", vcount_o, s0.v);
    check("th_flag_rise", th_flag_rise, fg(s0) && !fg(s1));
    check("th_flag_fall", th_flag_fall, !fg(s0) && fg(s1));
    check("vs_rise", TFT_VS_rise, s0.vs && !s1.vs);
    check("vs_fall", TFT_VS_fall, !s0.vs && s1.vs);
    check("frame_cnt", frame_cnt, exp_cnt);
    check("hcount_l", hcount_l, box_l);
    check("hcount_r", hcount_r, box_r);
    check("vcount_l", vcount_l, box_t);
    check("vcount_r", vcount_r, box_b);
    check("bbox_valid", bbox_valid, exp_valid);
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 8'd255, 12'd0, 12'd0);
  endtask

  task automatic vs_pulse(input bit with_px);
    drive_cycle(1'b1, with_px, 8'd0, 12'd250, 12'd100);
    drive_cycle(1'b1, 1'b0, 8'd255, 12'd0, 12'd0);
    drive_cycle(1'b1, 1'b0, 8'd255, 12'd0, 12'd0);
    idle();
    idle();
    n_frames++;
    $display("frame %0d: cnt=%0d box x %0d..%0d y %0d..%0d valid=%0d", n_frames, frame_cnt,
             hcount_l, hcount_r, vcount_l, vcount_r, bbox_valid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    TFT_VS = 1'b0; TFT_DE = 1'b0; gray = 8'd255; hcount = 12'd0; vcount = 12'd0;
    #1;
    check("rst_th_flag", th_flag, 0);
    check("rst_hcount_o", hcount_o, 0);
    check("rst_vs_rise", TFT_VS_rise, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_hcount_l", hcount_l, ROI_X0);
    check("rst_hcount_r", hcount_r, ROI_X1);
    check("rst_vcount_l", vcount_l, ROI_Y0);
    check("rst_vcount_r", vcount_r, ROI_Y1);
    check("rst_bbox_valid", bbox_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    $display("reset applied");
  endtask

  initial begin
    n_frames = 0;
    model_reset();
    do_reset();

    // Binarize threshold boundary.
    drive_cycle(1'b0, 1'b1, 8'd99, 12'd10, 12'd10);
    check("bin_99", th_flag, 1);
    drive_cycle(1'b0, 1'b1, 8'd100, 12'd11, 12'd10);
    check("bin_100", th_flag, 0);
    check("bin_fall", th_flag_fall, 1);
    idle();
    vs_pulse(1'b0);

    // Dark rectangle, then an all-white frame that must hold the box.
    for (int v = 90; v <= 170; v++)
      for (int h = 200; h <= 240; h++)
        drive_cycle(1'b0, 1'b1, 8'd20, 12'(h), 12'(v));
    vs_pulse(1'b1);
    check("rect_l", hcount_l, RECT_L);
    check("rect_r", hcount_r, 240);
    check("rect_t", vcount_l, 90);
    check("rect_b", vcount_r, 170);
    check("rect_valid", bbox_valid, 1);
    for (int h = 150; h < 250; h++) drive_cycle(1'b0, 1'b1, 8'd255, 12'(h), 12'd100);
    vs_pulse(1'b0);
    check("empty_l", hcount_l, RECT_L);
    check("empty_r", hcount_r, 240);
    check("empty_t", vcount_l, 90);
    check("empty_b", vcount_r, 170);
    check("empty_valid", bbox_valid, 0);

    // ROI clip: the pixel at x=50 lies left of the window.
    drive_cycle(1'b0, 1'b1, 8'd0, 12'd50, 12'd100);
    idle();
    drive_cycle(1'b0, 1'b1, 8'd0, 12'd300, 12'd100);
    idle();
    vs_pulse(1'b0);
`ifndef DIGIT_BBOX_RUNFILT_EN
    check("clip_l", hcount_l, 300);
    check("clip_r", hcount_r, 300);
    check("clip_t", vcount_l, 100);
    check("clip_b", vcount_r, 100);
`endif

    // Isolated speck plus a short run.
    idle();
    drive_cycle(1'b0, 1'b1, 8'd0, 12'd150, 12'd100);
    drive_cycle(1'b0, 1'b1, 8'd200, 12'd151, 12'd100);
    for (int h = 210; h <= 212; h++) drive_cycle(1'b0, 1'b1, 8'd0, 12'(h), 12'd120);
    drive_cycle(1'b0, 1'b1, 8'd200, 12'd213, 12'd120);
    vs_pulse(1'b0);
    check("run_l", hcount_l, RUN_L);
    check("run_r", hcount_r, RUN_R);
    check("run_t", vcount_l, RUN_T);
    check("run_b", vcount_r, RUN_B);

    // Random frames with a mix of runs, jumps, blanking and empty frames.
    for (int f = 0; f < 12; f++) begin
      logic [11:0] h, v;
      logic [7:0] g;
      h = 12'd0; v = 12'd0;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 1) == 0) h = h + 12'd1;
        else begin
          h = 12'($urandom_range(0, 450));
          v = 12'($urandom_range(0, 280));
        end
        g = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 120)) : 8'($urandom_range(80, 255));
        if (f % 4 == 3) g = 8'd255;
        drive_cycle(1'b0, 1'($urandom_range(0, 3) != 0), g, h, v);
      end
      vs_pulse(1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an accumulating frame, then counter wrap.
    for (int i = 0; i < 20; i++)
      drive_cycle(1'b0, 1'b1, 8'd0, 12'(200 + i), 12'd150);
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      vs_pulse(1'b0);
      check("cnt_seq", frame_cnt, i % FRAME_NUM);
    end
    check("post_rst_valid", bbox_valid, 0);
    check("post_rst_l", hcount_l, ROI_X0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
